data_mem_responder: RTL

- Memory-side responder for the core's load/store port; the other end of the control unit's addr / rd_en / wr_en / mem_write / mem_read interface.
- Holds a word-organised data RAM.
- Services one load or store at a time with a configurable wait-state count.
- Performs byte/half/word lane selection and sign/zero extension, and reports protocol errors (misaligned, out-of-range, conflicting request).

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
//   - Access size encodings carried on the size port.
//   - FSM state encoding.
//   - Latched request record.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign_ext;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering between the 32-bit RAM word and the
// right-aligned core data bus. Purely combinational.
//   size_i     : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   lane_i     : addr[1:0] of the access
//   sign_ext_i : load extension select (ignored for words)
//   wdata_i    : right-aligned store data
//   rword_i    : RAM word being loaded
//   be_o       : per-byte write enables for a store
//   wdata_o    : store data replicated onto the addressed lanes
//   rdata_o    : extracted and extended load data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{lane_i, 3'b000} +: 8];
  // Half accesses are only legal on even lanes, so lane[1] picks the half.
  assign rhalf = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port. One access in flight;
// the request is latched in IDLE, held for WAIT_CYCLES, executed in RESP and
// its result registered, so resp_valid/err/mem_read appear the cycle after RESP.
//   clk, rst     : clock, async active-low reset
//   addr         : byte address
//   rd_en, wr_en : load / store request (both high is an error)
//   mem_write    : right-aligned store data
//   size         : 0 byte, 1 half, 2 word, 3 reserved
//   sign_ext     : load extension select
//   ready        : request accepted at the next edge
//   mem_read     : load result, held until next load or error
//   resp_valid   : one-cycle completion pulse
//   err          : access rejected (qualifies resp_valid)
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        ready,
  output logic [31:0] mem_read,
  output logic        resp_valid,
  output logic        err
);

  localparam int          IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WLAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;

  logic [3:0][7:0] ram [DEPTH];

  logic [31:0]     off;
  logic [IDXW-1:0] idx;
  logic            oob, misal, acc_err, we;
  logic [3:0]      be;
  logic [31:0]     wsh, ld_data, rword;

  // Request validation is done on the latched copy.
  assign off     = req_q.addr - BASE_ADDR;
  assign idx     = off[IDXW+1:2];
  assign oob     = (req_q.addr < BASE_ADDR) || ({1'b0, off} >= LIMIT);
  assign misal   = ((req_q.size == SZ_HALF) && req_q.addr[0]) ||
                   ((req_q.size == SZ_WORD) && (req_q.addr[1:0] != 2'b00));
  assign acc_err = (req_q.rd && req_q.wr) || (req_q.size == SZ_RSVD) || misal || oob;
  assign rword   = ram[idx];

  mem_lane_align u_align (
    .size_i     (req_q.size),
    .lane_i     (req_q.addr[1:0]),
    .sign_ext_i (req_q.sign_ext),
    .wdata_i    (req_q.wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wsh),
    .rdata_o    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          req_d = '{rd: rd_en, wr: wr_en, addr: addr, wdata: mem_write,
                    size: size, sign_ext: sign_ext};
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WLAST) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rv_d    = 1'b1;
        err_d   = acc_err;
        // A conflicting rd+wr always errors, so rd here means a pure load.
        if (acc_err)       rdata_d = 32'h0;
        else if (req_q.rd) rdata_d = ld_data;
        we = req_q.wr && !acc_err;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'h0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; reset forces IDLE so an aborted store never writes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[idx][b] <= wsh[b*8 +: 8];
      end
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign mem_read   = rdata_q;
  assign resp_valid = rv_q;
  assign err        = err_q;

endmodule
